// File: rtl/fp_insn_encoder.sv
// fp_insn_encoder
//   Turns a decoded single-precision FP operation request into a 32-bit
//   RV32F instruction word. Encoded words are queued in a small output FIFO.
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   rst_ni         synchronous active-low reset
//   req_valid_i    encode request valid
//   req_ready_o    FIFO has room; a request is taken when valid && ready
//   cmd_i          operation select (0..25 legal, 26..31 illegal)
//   rd_i/rs1_i/rs2_i/rs3_i  register indices
//   rm_i           rounding mode
//   imm_i          load/store byte offset
//   flush_i        synchronous FIFO clear
//   instr_o        instruction at FIFO head, 0 when empty
//   instr_valid_o  FIFO non-empty
//   instr_ready_i  consumer takes instr_o when valid && ready
//   err_o          one-cycle pulse the cycle after a rejected request
//   issued_cnt_o   saturating count of delivered instructions
//   err_cnt_o      saturating count of rejected requests
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Valid must not depend on ready. req_ready_o depends only on FIFO
// state, never on req_valid_i or on a same-cycle pop.

module fp_insn_encoder #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [4:0]  cmd_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [4:0]  rs3_i,
  input  logic [2:0]  rm_i,
  input  logic [11:0] imm_i,
  input  logic        flush_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic        err_o,
  output logic [15:0] issued_cnt_o,
  output logic [7:0]  err_cnt_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [4:0] {
    CMD_FLW       = 5'd0,
    CMD_FSW       = 5'd1,
    CMD_FMADD     = 5'd2,
    CMD_FMSUB     = 5'd3,
    CMD_FNMSUB    = 5'd4,
    CMD_FNMADD    = 5'd5,
    CMD_FADD      = 5'd6,
    CMD_FSUB      = 5'd7,
    CMD_FMUL      = 5'd8,
    CMD_FDIV      = 5'd9,
    CMD_FSQRT     = 5'd10,
    CMD_FSGNJ     = 5'd11,
    CMD_FSGNJN    = 5'd12,
    CMD_FSGNJX    = 5'd13,
    CMD_FMIN      = 5'd14,
    CMD_FMAX      = 5'd15,
    CMD_FCVT_W_S  = 5'd16,
    CMD_FCVT_WU_S = 5'd17,
    CMD_FMV_X_W   = 5'd18,
    CMD_FEQ       = 5'd19,
    CMD_FLT       = 5'd20,
    CMD_FLE       = 5'd21,
    CMD_FCLASS    = 5'd22,
    CMD_FCVT_S_W  = 5'd23,
    CMD_FCVT_S_WU = 5'd24,
    CMD_FMV_W_X   = 5'd25
  } cmd_e;

  localparam logic [6:0] OP_LOAD_FP  = 7'h07;
  localparam logic [6:0] OP_STORE_FP = 7'h27;
  localparam logic [6:0] OP_FMADD    = 7'h43;
  localparam logic [6:0] OP_FMSUB    = 7'h47;
  localparam logic [6:0] OP_FNMSUB   = 7'h4B;
  localparam logic [6:0] OP_FNMADD   = 7'h4F;
  localparam logic [6:0] OP_FP       = 7'h53;

  localparam logic [2:0] F3_WORD     = 3'b010;

  // ---------------------------------------------------------------------
  // Encoder
  // ---------------------------------------------------------------------
  logic [31:0] enc_word;
  logic        enc_legal;
  logic        cmd_known;
  logic        uses_rm;
  logic        is_op_fp;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [4:0]  rs2_field;
  logic        rm_reserved;

  // 101 and 110 are reserved rounding modes; 111 (dynamic) is legal.
  assign rm_reserved = (rm_i == 3'b101) || (rm_i == 3'b110);

  always_comb begin
    enc_word  = '0;
    cmd_known = 1'b1;
    uses_rm   = 1'b0;
    is_op_fp  = 1'b0;
    f7        = 7'h00;
    f3        = rm_i;
    rs2_field = rs2_i;

    case (cmd_i)
      CMD_FLW: enc_word = {imm_i, rs1_i, F3_WORD, rd_i, OP_LOAD_FP};
      CMD_FSW: enc_word = {imm_i[11:5], rs2_i, rs1_i, F3_WORD, imm_i[4:0], OP_STORE_FP};

      CMD_FMADD: begin
        uses_rm  = 1'b1;
        enc_word = {rs3_i, 2'b00, rs2_i, rs1_i, rm_i, rd_i, OP_FMADD};
      end
      CMD_FMSUB: begin
        uses_rm  = 1'b1;
        enc_word = {rs3_i, 2'b00, rs2_i, rs1_i, rm_i, rd_i, OP_FMSUB};
      end
      CMD_FNMSUB: begin
        uses_rm  = 1'b1;
        enc_word = {rs3_i, 2'b00, rs2_i, rs1_i, rm_i, rd_i, OP_FNMSUB};
      end
      CMD_FNMADD: begin
        uses_rm  = 1'b1;
        enc_word = {rs3_i, 2'b00, rs2_i, rs1_i, rm_i, rd_i, OP_FNMADD};
      end

      CMD_FADD: begin
        is_op_fp = 1'b1; uses_rm = 1'b1; f7 = 7'h00;
      end
      CMD_FSUB: begin
        is_op_fp = 1'b1; uses_rm = 1'b1; f7 = 7'h04;
      end
      CMD_FMUL: begin
        is_op_fp = 1'b1; uses_rm = 1'b1; f7 = 7'h08;
      end
      CMD_FDIV: begin
        is_op_fp = 1'b1; uses_rm = 1'b1; f7 = 7'h0C;
      end
      CMD_FSQRT: begin
        is_op_fp = 1'b1; uses_rm = 1'b1; f7 = 7'h2C; rs2_field = 5'd0;
      end

      // Sign-injection, min/max and compares carry a sub-op in funct3.
      CMD_FSGNJ: begin
        is_op_fp = 1'b1; f7 = 7'h10; f3 = 3'b000;
      end
      CMD_FSGNJN: begin
        is_op_fp = 1'b1; f7 = 7'h10; f3 = 3'b001;
      end
      CMD_FSGNJX: begin
        is_op_fp = 1'b1; f7 = 7'h10; f3 = 3'b010;
      end
      CMD_FMIN: begin
        is_op_fp = 1'b1; f7 = 7'h14; f3 = 3'b000;
      end
      CMD_FMAX: begin
        is_op_fp = 1'b1; f7 = 7'h14; f3 = 3'b001;
      end

      // Conversions: rs2 field selects signed (0) or unsigned (1) integer.
      CMD_FCVT_W_S: begin
        is_op_fp = 1'b1; uses_rm = 1'b1; f7 = 7'h60; rs2_field = 5'd0;
      end
      CMD_FCVT_WU_S: begin
        is_op_fp = 1'b1; uses_rm = 1'b1; f7 = 7'h60; rs2_field = 5'd1;
      end
      CMD_FCVT_S_W: begin
        is_op_fp = 1'b1; uses_rm = 1'b1; f7 = 7'h68; rs2_field = 5'd0;
      end
      CMD_FCVT_S_WU: begin
        is_op_fp = 1'b1; uses_rm = 1'b1; f7 = 7'h68; rs2_field = 5'd1;
      end

      CMD_FMV_X_W: begin
        is_op_fp = 1'b1; f7 = 7'h70; f3 = 3'b000; rs2_field = 5'd0;
      end
      CMD_FCLASS: begin
        is_op_fp = 1'b1; f7 = 7'h70; f3 = 3'b001; rs2_field = 5'd0;
      end
      CMD_FMV_W_X: begin
        is_op_fp = 1'b1; f7 = 7'h78; f3 = 3'b000; rs2_field = 5'd0;
      end

      CMD_FEQ: begin
        is_op_fp = 1'b1; f7 = 7'h50; f3 = 3'b010;
      end
      CMD_FLT: begin
        is_op_fp = 1'b1; f7 = 7'h50; f3 = 3'b001;
      end
      CMD_FLE: begin
        is_op_fp = 1'b1; f7 = 7'h50; f3 = 3'b000;
      end

      default: cmd_known = 1'b0;
    endcase

    if (is_op_fp) begin
      enc_word = {f7, rs2_field, rs1_i, f3, rd_i, OP_FP};
    end
  end

  assign enc_legal = cmd_known && !(uses_rm && rm_reserved);

  // ---------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          accept;
  logic          push;
  logic          pop;
  logic          reject;
  logic          err_q;
  logic [15:0]   issued_cnt_q;
  logic [7:0]    err_cnt_q;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A request is consumed whenever ready is high, legal or not. Illegal
  // requests are answered with err_o instead of an entry. Flush drops the
  // push and the pop but never hides the error report.
  assign accept = req_valid_i && !full;
  assign push   = accept && enc_legal && !flush_i;
  assign reject = accept && !enc_legal;
  assign pop    = !empty && instr_ready_i && !flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_ni && push) begin
      mem[wr_ptr] <= enc_word;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Error pulse and statistics
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q        <= 1'b0;
      issued_cnt_q <= '0;
      err_cnt_q    <= '0;
    end else begin
      err_q <= reject;
      if (pop && (issued_cnt_q != 16'hFFFF)) begin
        issued_cnt_q <= issued_cnt_q + 16'd1;
      end
      if (reject && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign req_ready_o   = !full;
  assign instr_valid_o = !empty;
  assign instr_o       = empty ? 32'd0 : mem[rd_ptr];
  assign err_o         = err_q;
  assign issued_cnt_o  = issued_cnt_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_fp_insn_encoder.sv
// tb_fp_insn_encoder
//   Directed plus random stimulus for fp_insn_encoder (DEPTH=4). A reference
//   encoder and a FIFO model predict every output; queued words live in
//   exp_q and are popped when the consumer takes them.

module tb_fp_insn_encoder;

  localparam int DEPTH = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid;
  logic        req_ready_o;
  logic [4:0]  cmd;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rs3;
  logic [2:0]  rm;
  logic [11:0] imm;
  logic        flush;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        instr_ready;
  logic        err_o;
  logic [15:0] issued_cnt_o;
  logic [7:0]  err_cnt_o;

  fp_insn_encoder #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .cmd_i        (cmd),
    .rd_i         (rd),
    .rs1_i        (rs1),
    .rs2_i        (rs2),
    .rs3_i        (rs3),
    .rm_i         (rm),
    .imm_i        (imm),
    .flush_i      (flush),
    .instr_o      (instr_o),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready),
    .err_o        (err_o),
    .issued_cnt_o (issued_cnt_o),
    .err_cnt_o    (err_cnt_o)
  );

  // scoreboard state
  logic [31:0] exp_q[$];
  logic [15:0] m_issued;
  logic [7:0]  m_errcnt;
  logic        m_err;
  int          n_vec  = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference encoder: returns {legal, word}.
  function automatic logic [32:0] ref_enc(input logic [4:0] c, input logic [4:0] d,
                                          input logic [4:0] s1, input logic [4:0] s2,
                                          input logic [4:0] s3, input logic [2:0] r,
                                          input logic [11:0] im);
    logic [6:0]  f7;
    logic [4:0]  f2;
    logic [2:0]  f3;
    logic [6:0]  opc;
    logic        rmop;
    logic        ok;
    logic [31:0] w;
    ok = 1'b1; rmop = 1'b0; f7 = 7'h00; f2 = s2; f3 = r; opc = 7'h53; w = 32'd0;
    if (c == 5'd0) begin
      w = {im, s1, 3'b010, d, 7'h07};
    end else if (c == 5'd1) begin
      w = {im[11:5], s2, s1, 3'b010, im[4:0], 7'h27};
    end else if (c <= 5'd5) begin
      rmop = 1'b1;
      case (c)
        5'd2:    opc = 7'h43;
        5'd3:    opc = 7'h47;
        5'd4:    opc = 7'h4B;
        default: opc = 7'h4F;
      endcase
      w = {s3, 2'b00, s2, s1, r, d, opc};
    end else if (c <= 5'd25) begin
      case (c)
        5'd6:  begin f7 = 7'h00; rmop = 1'b1; end
        5'd7:  begin f7 = 7'h04; rmop = 1'b1; end
        5'd8:  begin f7 = 7'h08; rmop = 1'b1; end
        5'd9:  begin f7 = 7'h0C; rmop = 1'b1; end
        5'd10: begin f7 = 7'h2C; rmop = 1'b1; f2 = 5'd0; end
        5'd11: begin f7 = 7'h10; f3 = 3'd0; end
        5'd12: begin f7 = 7'h10; f3 = 3'd1; end
        5'd13: begin f7 = 7'h10; f3 = 3'd2; end
        5'd14: begin f7 = 7'h14; f3 = 3'd0; end
        5'd15: begin f7 = 7'h14; f3 = 3'd1; end
        5'd16: begin f7 = 7'h60; rmop = 1'b1; f2 = 5'd0; end
        5'd17: begin f7 = 7'h60; rmop = 1'b1; f2 = 5'd1; end
        5'd18: begin f7 = 7'h70; f3 = 3'd0; f2 = 5'd0; end
        5'd19: begin f7 = 7'h50; f3 = 3'd2; end
        5'd20: begin f7 = 7'h50; f3 = 3'd1; end
        5'd21: begin f7 = 7'h50; f3 = 3'd0; end
        5'd22: begin f7 = 7'h70; f3 = 3'd1; f2 = 5'd0; end
        5'd23: begin f7 = 7'h68; rmop = 1'b1; f2 = 5'd0; end
        5'd24: begin f7 = 7'h68; rmop = 1'b1; f2 = 5'd1; end
        default: begin f7 = 7'h78; f3 = 3'd0; f2 = 5'd0; end
      endcase
      w = {f7, f2, s1, f3, d, 7'h53};
    end else begin
      ok = 1'b0;
    end
    if (rmop && (r == 3'd5 || r == 3'd6)) ok = 1'b0;
    return {ok, w};
  endfunction

  // driver tasks
  task automatic set_idle();
    req_valid = 1'b0; flush = 1'b0; instr_ready = 1'b0;
    cmd = 5'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; rs3 = 5'd0; rm = 3'd0; imm = 12'd0;
  endtask

  task automatic set_req(input logic [4:0] c, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [4:0] s3, input logic [2:0] r,
                         input logic [11:0] im);
    req_valid = 1'b1; cmd = c; rd = d; rs1 = s1; rs2 = s2; rs3 = s3; rm = r; imm = im;
  endtask

  // One clock: predict from pre-edge model state, advance, compare #1 later.
  task automatic cycle();
    logic        full_m;
    logic        acc;
    logic [32:0] e;
    full_m = (exp_q.size() == DEPTH);
    e      = ref_enc(cmd, rd, rs1, rs2, rs3, rm, imm);
    acc    = req_valid && !full_m;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      exp_q.delete();
      m_issued = 16'd0;
      m_errcnt = 8'd0;
      m_err    = 1'b0;
    end else begin
      m_err = acc && !e[32];
      if (m_err && m_errcnt != 8'hFF) m_errcnt++;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() > 0 && instr_ready) begin
          void'(exp_q.pop_front());
          if (m_issued != 16'hFFFF) m_issued++;
        end
        if (acc && e[32]) exp_q.push_back(e[31:0]);
      end
    end
    check("instr_valid", 32'(instr_valid_o), 32'(exp_q.size() > 0));
    check("instr_word",  instr_o, (exp_q.size() > 0) ? exp_q[0] : 32'd0);
    check("req_ready",   32'(req_ready_o), 32'(exp_q.size() != DEPTH));
    check("err_pulse",   32'(err_o), 32'(m_err));
    check("issued_cnt",  32'(issued_cnt_o), 32'(m_issued));
    check("err_cnt",     32'(err_cnt_o), 32'(m_errcnt));
  endtask

  task automatic pop_one();
    set_idle(); instr_ready = 1'b1; cycle(); instr_ready = 1'b0;
  endtask

  initial begin
    exp_q.delete();
    m_issued = 16'd0; m_errcnt = 8'd0; m_err = 1'b0;
    set_idle();

    // reset state
    rst_n = 1'b0;
    cycle(); cycle();
    check("rst_ready", 32'(req_ready_o), 32'd1);
    check("rst_instr", instr_o, 32'd0);
    rst_n = 1'b1;
    cycle();

    // FADD rd=3 rs1=1 rs2=2 rm=000
    set_req(5'd6, 5'd3, 5'd1, 5'd2, 5'd0, 3'd0, 12'd0); cycle(); set_idle();
    check("fadd_word", instr_o, 32'h002081D3);
    check("fadd_valid", 32'(instr_valid_o), 32'd1);
    pop_one();

    // FLW / FSW
    set_req(5'd0, 5'd5, 5'd10, 5'd0, 5'd0, 3'd0, 12'h010); cycle(); set_idle();
    check("flw_word", instr_o, 32'h01052287);
    pop_one();
    set_req(5'd1, 5'd0, 5'd2, 5'd8, 5'd0, 3'd0, 12'h024); cycle(); set_idle();
    check("fsw_word", instr_o, 32'h02812227);
    pop_one();

    // FMADD legal rm=111, then reserved rm=101
    set_req(5'd2, 5'd1, 5'd2, 5'd3, 5'd4, 3'd7, 12'd0); cycle(); set_idle();
    check("fmadd_word", instr_o, 32'h203170C3);
    pop_one();
    set_req(5'd2, 5'd1, 5'd2, 5'd3, 5'd4, 3'd5, 12'd0); cycle(); set_idle();
    check("fmadd_rm5_err", 32'(err_o), 32'd1);
    check("fmadd_rm5_errcnt", 32'(err_cnt_o), 32'd1);
    check("fmadd_rm5_empty", 32'(instr_valid_o), 32'd0);
    cycle();

    // Fill from a fresh reset: 5 requests, 4 fit, then drain in order
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_req(5'd7, 5'(i + 1), 5'(i + 2), 5'(i + 3), 5'd0, 3'd1, 12'd0);
      cycle();
    end
    set_idle();
    check("full_ready_low", 32'(req_ready_o), 32'd0);
    for (int i = 0; i < 4; i++) pop_one();
    check("drain_issued", 32'(issued_cnt_o), 32'd4);
    check("drain_empty", 32'(instr_valid_o), 32'd0);

    // Flush with 2 queued plus concurrent push and pop
    for (int i = 0; i < 2; i++) begin
      set_req(5'd8, 5'(i), 5'd9, 5'd10, 5'd0, 3'd2, 12'd0); cycle();
    end
    set_req(5'd9, 5'd11, 5'd12, 5'd13, 5'd0, 3'd0, 12'd0);
    instr_ready = 1'b1; flush = 1'b1;
    cycle(); set_idle();
    check("flush_empty", 32'(instr_valid_o), 32'd0);
    check("flush_issued", 32'(issued_cnt_o), 32'd4);
    // illegal request during flush still reports
    set_req(5'd30, 5'd1, 5'd1, 5'd1, 5'd1, 3'd0, 12'd0); flush = 1'b1;
    cycle(); set_idle();
    check("flush_err", 32'(err_o), 32'd1);

    // Reset with 3 queued and a request presented during reset
    for (int i = 0; i < 3; i++) begin
      set_req(5'd14, 5'(i), 5'd3, 5'd4, 5'd0, 3'd0, 12'd0); cycle();
    end
    set_req(5'd15, 5'd1, 5'd2, 5'd3, 5'd0, 3'd0, 12'd0); instr_ready = 1'b1;
    rst_n = 1'b0; cycle(); rst_n = 1'b1; set_idle();
    check("rst_mid_valid", 32'(instr_valid_o), 32'd0);
    check("rst_mid_issued", 32'(issued_cnt_o), 32'd0);
    check("rst_mid_errcnt", 32'(err_cnt_o), 32'd0);
    cycle();

    // Consumer ready while empty
    instr_ready = 1'b1; cycle(); cycle(); set_idle();
    check("empty_pop_issued", 32'(issued_cnt_o), 32'd0);

    // Every command once with rm=111 and once with rm=110
    for (int c = 0; c < 32; c++) begin
      set_req(5'(c), 5'd17, 5'd18, 5'd19, 5'd20, 3'd7, 12'hA5C); cycle();
      pop_one();
      set_req(5'(c), 5'd21, 5'd22, 5'd23, 5'd24, 3'd6, 12'h3F1); cycle();
      pop_one();
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      req_valid   = 1'($urandom_range(0, 1));
      cmd         = 5'($urandom_range(0, 31));
      rd          = 5'($urandom_range(0, 31));
      rs1         = 5'($urandom_range(0, 31));
      rs2         = 5'($urandom_range(0, 31));
      rs3         = 5'($urandom_range(0, 31));
      rm          = 3'($urandom_range(0, 7));
      imm         = 12'($urandom_range(0, 4095));
      instr_ready = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 24) == 0);
      cycle();
    end
    set_idle();

    // err_cnt saturation
    for (int i = 0; i < 270; i++) begin
      set_req(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 12'd0); cycle();
    end
    set_idle(); cycle();
    check("errcnt_sat", 32'(err_cnt_o), 32'hFF);

    for (int i = 0; i < DEPTH + 1; i++) pop_one();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
